// File: rtl/ppu_oam_dma.sv
// Sprite OAM DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies one page into OAM.
// Define OAM_DMA_ALIGN_EN to add the odd-cycle alignment state before the first read.
module ppu_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic [7:0]  oam_addr_reg,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_halt,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_in,
  output logic        dma_busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam logic [BYTE_W-1:0] LAST_IDX = BYTE_W'(XFER_LEN - 1);

`ifdef OAM_DMA_ALIGN_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              parity_q, parity_d;
  logic [BYTE_W-1:0] page_q, page_d;
  logic [BYTE_W-1:0] base_q, base_d;
  logic [BYTE_W-1:0] idx_q, idx_d;
  logic              cpu_halt_q, cpu_halt_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
  logic              dma_rd_q, dma_rd_d;
  logic              oam_dma_q, oam_dma_d;
  logic [BYTE_W-1:0] oam_addr_q, oam_addr_d;
  logic [BYTE_W-1:0] oam_data_q, oam_data_d;
  logic              dma_busy_q, dma_busy_d;
  logic              trigger_c;

  assign trigger_c = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // State, parity and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      parity_q   <= 1'b0;
      page_q     <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      cpu_halt_q <= 1'b0;
      dma_addr_q <= '0;
      dma_rd_q   <= 1'b0;
      oam_dma_q  <= 1'b0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
      dma_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      page_q     <= page_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      cpu_halt_q <= cpu_halt_d;
      dma_addr_q <= dma_addr_d;
      dma_rd_q   <= dma_rd_d;
      oam_dma_q  <= oam_dma_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
      dma_busy_q <= dma_busy_d;
    end
  end

  // Next state; outputs are decoded from the next state so they change with it
  always_comb begin
    state_d    = state_q;
    parity_d   = parity_q;
    page_d     = page_q;
    base_d     = base_q;
    idx_d      = idx_q;
    oam_addr_d = oam_addr_q;
    oam_data_d = oam_data_q;
    oam_dma_d  = 1'b0;

    if (cpu_ce) begin
      parity_d = ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (trigger_c) begin
            page_d  = cpu_wdata;
            base_d  = oam_addr_reg;
            idx_d   = '0;
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          state_d = (ALIGN_EN && parity_q) ? S_ALIGN : S_READ;
        end
        S_ALIGN: begin
          state_d = S_READ;
        end
        S_READ: begin
          // Read byte goes straight to the OAM write port; strobe lasts one clk
          oam_data_d = bus_rdata;
          oam_addr_d = base_q + idx_q;
          oam_dma_d  = 1'b1;
          state_d    = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    dma_rd_d   = (state_d == S_READ);
    dma_addr_d = dma_rd_d ? {page_d, idx_d} : '0;
    cpu_halt_d = (state_d != S_IDLE);
    dma_busy_d = (state_d != S_IDLE);
  end

  assign cpu_halt    = cpu_halt_q;
  assign dma_addr    = dma_addr_q;
  assign dma_rd      = dma_rd_q;
  assign oam_dma     = oam_dma_q;
  assign oam_addr    = oam_addr_q;
  assign oam_data_in = oam_data_q;
  assign dma_busy    = dma_busy_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Randomized bench for ppu_oam_dma: bus memory + OAM array model, expected OAM computed from page/base.
// Honours OAM_DMA_ALIGN_EN when computing expected cycle counts.
module tb_ppu_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_EN = 1;
`else
  localparam int ALIGN_EN = 0;
`endif
  localparam int XFER = 256;
  localparam int BASE_CYCLES = 1 + 2 * XFER;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  oam_addr_reg;
  logic [7:0]  bus_rdata;
  logic        cpu_halt;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        oam_dma;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_in;
  logic        dma_busy;

  logic [7:0] mem [0:65535];
  logic [7:0] oam_dut [0:255];
  logic [7:0] oam_exp [0:255];

  int n_checks = 0;
  int n_fail = 0;
  int ce_cnt, ce_div, clk_ph;
  int halt_ces, wr_cnt, pulse_bad, addr_bad, first_rd, trig_ce, exp_rd_k;
  logic prev_oam_dma;
  logic [7:0] cur_page;

  always #5 clk = ~clk;

  assign bus_rdata = mem[dma_addr];

  ppu_oam_dma dut (
    .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .oam_addr_reg(oam_addr_reg),
    .bus_rdata(bus_rdata), .cpu_halt(cpu_halt), .dma_addr(dma_addr),
    .dma_rd(dma_rd), .oam_dma(oam_dma), .oam_addr(oam_addr),
    .oam_data_in(oam_data_in), .dma_busy(dma_busy)
  );

  // One clk: drive cpu_ce, observe registered outputs mid-cycle, advance to posedge+1
  task automatic step();
    logic ce;
    ce = (clk_ph == 0);
    clk_ph = (clk_ph + 1) % ce_div;
    cpu_ce = ce;
    #2;
    if (oam_dma) begin
      oam_dut[oam_addr] = oam_data_in;
      wr_cnt++;
      if (prev_oam_dma) pulse_bad++;
    end
    prev_oam_dma = oam_dma;
    if (dma_rd) begin
      if (dma_addr !== {cur_page, 8'(exp_rd_k)}) addr_bad++;
    end else if (dma_addr !== 16'h0000) begin
      addr_bad++;
    end
    if (ce && dma_rd) begin
      if (first_rd < 0) first_rd = ce_cnt - trig_ce;
      exp_rd_k++;
    end
    if (ce && cpu_halt) halt_ces++;
    if (ce) ce_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ce_cnt = 0; clk_ph = 0; prev_oam_dma = 1'b0;
  endtask

  // Expected OAM after n bytes of page copied from base (wraps mod 256)
  task automatic build_expect(input logic [7:0] page, input logic [7:0] base, input int n);
    for (int k = 0; k < 256; k++) oam_exp[k] = oam_dut[k];
    for (int k = 0; k < n; k++) oam_exp[8'(base + k)] = mem[{page, 8'(k)}];
  endtask

  // Trigger a transfer and step it. want_par: parity of the trigger cycle (-1 any).
  // inject_at: issue a second $4014 write once that many reads have happened (-1 none).
  // stop_wr: return once that many OAM writes have been seen (-1 run to completion).
  task automatic run_dma(input logic [7:0] page, input logic [7:0] base, input int want_par,
                         input int inject_at, input int stop_wr, output int timed_out);
    int guard;
    logic injected;
    timed_out = 0;
    injected = 1'b0;
    oam_addr_reg = base;
    guard = 0;
    while (!(clk_ph == 0 && (want_par < 0 || (ce_cnt % 2) == want_par)) && guard < 10) begin
      step(); guard++;
    end
    halt_ces = 0; wr_cnt = 0; pulse_bad = 0; addr_bad = 0; first_rd = -1; exp_rd_k = 0;
    cur_page = page;
    trig_ce = ce_cnt;
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = page;
    step();
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    guard = 0;
    while (dma_busy && guard < 5000 && !(stop_wr >= 0 && wr_cnt >= stop_wr)) begin
      if (!injected && inject_at >= 0 && clk_ph == 0 && exp_rd_k == inject_at) begin
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h05;
        oam_addr_reg = 8'($urandom);
        injected = 1'b1;
        step();
        cpu_we = 1'b0; cpu_addr = 16'h0000;
      end else begin
        step();
      end
      guard++;
    end
    if (guard >= 5000) timed_out = 1;
  endtask

  // Shared completion checks, done inline by each scenario through this macro-free block
  task automatic check_done(input string name, input int to, input int exp_cycles);
    int bad;
    n_checks++;
    if (to !== 0) begin
      n_fail++; $display("FAIL %s timeout: dma_busy still %0b after 5000 clks", name, dma_busy);
    end
    n_checks++;
    if (halt_ces !== exp_cycles) begin
      n_fail++; $display("FAIL %s cycles: got %0d want %0d", name, halt_ces, exp_cycles);
    end
    n_checks++;
    if (wr_cnt !== XFER) begin
      n_fail++; $display("FAIL %s writes: got %0d want %0d", name, wr_cnt, XFER);
    end
    n_checks++;
    if (pulse_bad !== 0 || addr_bad !== 0) begin
      n_fail++; $display("FAIL %s strobes: pulse_bad %0d addr_bad %0d want 0 0", name, pulse_bad, addr_bad);
    end
    bad = 0;
    for (int k = 0; k < 256; k++) if (oam_dut[k] !== oam_exp[k]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL %s oam: %0d bytes differ, want 0", name, bad);
    end
    n_checks++;
    if (dma_busy !== 1'b0 || cpu_halt !== 1'b0) begin
      n_fail++; $display("FAIL %s idle: busy %0b halt %0b want 0 0", name, dma_busy, cpu_halt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({cpu_halt, dma_addr, dma_rd, oam_dma, oam_addr, oam_data_in, dma_busy} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {cpu_halt, dma_addr, dma_rd, oam_dma, oam_addr, oam_data_in, dma_busy});
    end
  endtask

  task automatic test_basic();
    int to;
    build_expect(8'h02, 8'h00, XFER);
    run_dma(8'h02, 8'h00, 1, -1, -1, to);
    check_done("basic", to, BASE_CYCLES);
    n_checks++;
    if (first_rd !== 2) begin
      n_fail++; $display("FAIL basic first_rd: got %0d ce want 2", first_rd);
    end
  endtask

  task automatic test_align();
    int to;
    build_expect(8'h02, 8'h00, XFER);
    run_dma(8'h02, 8'h00, 0, -1, -1, to);
    check_done("align", to, BASE_CYCLES + ALIGN_EN);
    n_checks++;
    if (first_rd !== 2 + ALIGN_EN) begin
      n_fail++; $display("FAIL align first_rd: got %0d ce want %0d", first_rd, 2 + ALIGN_EN);
    end
  endtask

  task automatic test_wrap();
    int to;
    build_expect(8'h03, 8'hF0, XFER);
    run_dma(8'h03, 8'hF0, -1, -1, -1, to);
    check_done("wrap", to, BASE_CYCLES + ALIGN_EN * ((trig_ce + 1) % 2));
    n_checks++;
    if (oam_dut[8'hF0] !== mem[16'h0300] || oam_dut[8'h00] !== mem[16'h0310] ||
        oam_dut[8'hEF] !== mem[16'h03FF]) begin
      n_fail++;
      $display("FAIL wrap spots: F0=%h 00=%h EF=%h want %h %h %h", oam_dut[8'hF0], oam_dut[8'h00],
               oam_dut[8'hEF], mem[16'h0300], mem[16'h0310], mem[16'h03FF]);
    end
  endtask

  task automatic test_retrigger();
    int to;
    build_expect(8'h03, 8'h20, XFER);
    run_dma(8'h03, 8'h20, -1, 40, -1, to);
    check_done("retrigger", to, BASE_CYCLES + ALIGN_EN * ((trig_ce + 1) % 2));
  endtask

  task automatic test_back_to_back();
    int to;
    build_expect(8'h07, 8'h11, XFER);
    run_dma(8'h07, 8'h11, -1, XFER, -1, to);
    check_done("final_write_trig", to, BASE_CYCLES + ALIGN_EN * ((trig_ce + 1) % 2));
    halt_ces = 0;
    repeat (6) step();
    n_checks++;
    if (halt_ces !== 0 || dma_busy !== 1'b0) begin
      n_fail++; $display("FAIL final_write_trig restart: halts %0d busy %0b want 0 0", halt_ces, dma_busy);
    end
  endtask

  task automatic test_reset_mid();
    int to;
    for (int k = 0; k < 256; k++) oam_dut[k] = 8'(k ^ 8'h5A);
    build_expect(8'h04, 8'h00, 100);
    run_dma(8'h04, 8'h00, -1, -1, 100, to);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_halt, dma_addr, dma_rd, oam_dma, oam_addr, oam_data_in, dma_busy} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got %h want 0",
               {cpu_halt, dma_addr, dma_rd, oam_dma, oam_addr, oam_data_in, dma_busy});
    end
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (oam_dut[k] !== oam_exp[k]) bad++;
      n_checks++;
      if (bad !== 0 || wr_cnt !== 100) begin
        n_fail++; $display("FAIL reset_mid partial: %0d bytes differ, %0d writes; want 0, 100", bad, wr_cnt);
      end
    end
    do_reset();
    build_expect(8'h06, 8'h80, XFER);
    run_dma(8'h06, 8'h80, -1, -1, -1, to);
    check_done("after_reset", to, BASE_CYCLES + ALIGN_EN * ((trig_ce + 1) % 2));
  endtask

  task automatic test_slow_ce();
    int to;
    logic [7:0] b;
    b = 8'($urandom);
    ce_div = 3; clk_ph = 0;
    build_expect(8'hFF, b, XFER);
    run_dma(8'hFF, b, -1, -1, -1, to);
    check_done("slow_ce", to, BASE_CYCLES + ALIGN_EN * ((trig_ce + 1) % 2));
    ce_div = 1; clk_ph = 0;
  endtask

  task automatic test_random();
    int to;
    logic [7:0] p, b;
    for (int r = 0; r < 3; r++) begin
      p = 8'($urandom); b = 8'($urandom);
      ce_div = 1 + (r % 2); clk_ph = 0;
      build_expect(p, b, XFER);
      run_dma(p, b, int'($urandom_range(0, 1)), -1, -1, to);
      check_done("random", to, BASE_CYCLES + ALIGN_EN * ((trig_ce + 1) % 2));
    end
    ce_div = 1; clk_ph = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < 256; k++) oam_dut[k] = 8'h00;
    ce_div = 1; clk_ph = 0; ce_cnt = 0;
    oam_addr_reg = 8'h00;
    test_reset();
    test_basic();
    test_align();
    test_wrap();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    test_slow_ce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
